wb_cmd_master: RTL and testbench

Single-outstanding Wishbone classic initiator that turns valid/ready command beats into one Wishbone read or write cycle each and returns the read data or a timeout status on a valid/ready response channel. It is the requester side of the user-area Wishbone slave, which decodes 0x38xx_xxxx to firmware BRAM and 0x30xx_xxxx to the FIR/AXI bridge. It drives that slave from a test sequencer or an on-chip engine, in place of the management SoC.

---
 rtl/wb_cmd_master.sv | 105 ++++++++++
 tb/tb_wb_cmd_master.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone classic initiator: one command beat becomes one
// bus cycle, and its result comes back as one response beat (read data or timeout).
module wb_cmd_master #(
    parameter int TIMEOUT = 64,
    parameter int CW      = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_timeout,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          expire;

    // Expiry on the TIMEOUT-th BUS cycle; ack in the same cycle takes priority.
    assign expire    = (cnt == CW'(TIMEOUT - 1));
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid)             state_nxt = BUS;
            BUS:     if (wbm_ack_i || expire)   state_nxt = RESP;
            RESP:    if (rsp_ready)             state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= '0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            rsp_valid   <= 1'b0;
            rsp_dat     <= '0;
            rsp_timeout <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= cmd_we;
                        wbm_sel_o <= cmd_sel;
                        wbm_adr_o <= cmd_adr;
                        wbm_dat_o <= cmd_dat;
                        cnt       <= '0;
                    end
                end
                BUS: begin
                    cnt <= cnt + 1'b1;
                    if (wbm_ack_i) begin
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_dat     <= wbm_we_o ? 32'h0 : wbm_dat_i;
                        rsp_timeout <= 1'b0;
                    end else if (expire) begin
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_dat     <= 32'h0;
                        rsp_timeout <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: a delay-programmable Wishbone slave with word memory,
// plus a transaction-level reference model predicting latency, data and timeout.
module tb_wb_cmd_master;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0, cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_ready = 1'b0;
    logic        cmd_ready, rsp_valid, rsp_timeout, busy;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    wb_cmd_master #(.TIMEOUT(TIMEOUT), .CW(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_timeout(rsp_timeout),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .busy(busy)
    );

    // Slave: acks in BUS cycle ack_delay (0 = never); ack_force injects stray acks.
    int          ack_delay = 0;
    bit          ack_force = 1'b0;
    int          bus_cnt = 0;
    logic [31:0] smem [256];

    assign wbm_ack_i = ack_force ||
                       (wbm_cyc_o && wbm_stb_o && ack_delay != 0 && bus_cnt + 1 == ack_delay);
    assign wbm_dat_i = smem[wbm_adr_o[9:2]];

    always @(posedge clk) begin
        if (wbm_cyc_o && wbm_stb_o) bus_cnt <= bus_cnt + 1;
        else                        bus_cnt <= 0;
        if (rst) begin
            for (int i = 0; i < 256; i++) smem[i] <= (i == 0) ? 32'h1234_5678 : 32'h0;
        end else if (wbm_cyc_o && wbm_stb_o && wbm_ack_i && wbm_we_o) begin
            for (int b = 0; b < 4; b++)
                if (wbm_sel_o[b]) smem[wbm_adr_o[9:2]][8*b +: 8] <= wbm_dat_o[8*b +: 8];
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [256];

    task automatic model(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int delay,
                         output int e_lat, output logic [31:0] e_rd, output logic e_to);
        e_to  = (delay == 0) || (delay > TIMEOUT);
        e_lat = e_to ? TIMEOUT : delay;
        e_rd  = (e_to || we) ? 32'h0 : ref_mem[adr[9:2]];
        if (we && !e_to)
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[adr[9:2]][8*b +: 8] = dat[8*b +: 8];
    endtask

    // Drives one command and collects what the DUT did; checks are done by callers.
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int delay, input int hold,
                           input bit spur, output int lat, output logic [31:0] rd,
                           output logic to, output bit ok_bus, output bit ok_hold,
                           output bit ready_after, output bit done);
        int w;
        ack_delay = delay; ok_bus = 1; ok_hold = 1; lat = 0; rd = '0; to = 0;
        ready_after = 0; done = 0; w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 20) begin w++; @(negedge clk); end
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (!rsp_valid && lat < 200) begin
            if (!(wbm_cyc_o && wbm_stb_o && wbm_adr_o == adr && wbm_dat_o == dat &&
                  wbm_we_o == we && wbm_sel_o == sel && busy && !cmd_ready)) ok_bus = 0;
            lat++;
            @(negedge clk);
        end
        if (rsp_valid) begin
            if (wbm_cyc_o || wbm_stb_o) ok_bus = 0;
            rd = rsp_dat; to = rsp_timeout;
            for (int i = 0; i < hold; i++) begin
                cmd_valid = spur && i[0];
                cmd_adr   = ~adr;
                ack_force = spur;
                @(negedge clk);
                if (!rsp_valid || rsp_dat !== rd || rsp_timeout !== to || cmd_ready ||
                    wbm_cyc_o || wbm_stb_o) ok_hold = 0;
            end
            cmd_valid = 1'b0; ack_force = 1'b0;
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            ready_after = cmd_ready && !rsp_valid && !busy && !wbm_cyc_o;
            done = 1;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = (i == 0) ? 32'h1234_5678 : 32'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, rsp_valid, rsp_timeout} !== 9'b0 ||
            wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0 || rsp_dat !== 32'h0) begin
            failed++; $display("FAIL reset_outputs: got cyc=%b adr=%h rsp_valid=%b, required all 0",
                               wbm_cyc_o, wbm_adr_o, rsp_valid);
        end
        tests++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failed++; $display("FAIL reset_ready: got cmd_ready=%b busy=%b, required 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_write_read();
        int lat, e_lat; logic [31:0] rd, e_rd; logic to, e_to; bit ob, oh, ra, dn;
        model(1'b1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF, 11, e_lat, e_rd, e_to);
        run_txn(1'b1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF, 11, 0, 0, lat, rd, to, ob, oh, ra, dn);
        tests++;
        if (!dn || lat != 11 || !ob) begin
            failed++; $display("FAIL bram_write_cyc: got %0d cycles ok=%0d, required 11", lat, ob);
        end
        tests++;
        if (rd !== 32'h0 || to !== 1'b0) begin
            failed++; $display("FAIL bram_write_rsp: got dat=%h to=%b, required 0/0", rd, to);
        end
        model(1'b0, 32'h3800_0010, 32'h0, 4'hF, 11, e_lat, e_rd, e_to);
        run_txn(1'b0, 32'h3800_0010, 32'h0, 4'hF, 11, 0, 0, lat, rd, to, ob, oh, ra, dn);
        tests++;
        if (!dn || rd !== 32'hDEAD_BEEF || to !== 1'b0 || lat != 11) begin
            failed++; $display("FAIL bram_read: got dat=%h to=%b lat=%0d, required deadbeef/0/11", rd, to, lat);
        end
    endtask

    task automatic test_zero_wait();
        int lat, e_lat; logic [31:0] rd, e_rd; logic to, e_to; bit ob, oh, ra, dn;
        model(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1, e_lat, e_rd, e_to);
        run_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1, 0, 0, lat, rd, to, ob, oh, ra, dn);
        tests++;
        if (!dn || lat != 1 || !ob) begin
            failed++; $display("FAIL zero_wait_lat: got %0d ok=%0d, required 1", lat, ob);
        end
        tests++;
        if (rd !== 32'h1234_5678 || to !== 1'b0) begin
            failed++; $display("FAIL zero_wait_dat: got %h to=%b, required 12345678/0", rd, to);
        end
    endtask

    task automatic test_timeout();
        int lat; logic [31:0] rd; logic to; bit ob, oh, ra, dn;
        int e_lat; logic [31:0] e_rd; logic e_to;
        model(1'b0, 32'h3800_0020, 32'h0, 4'hF, 0, e_lat, e_rd, e_to);
        run_txn(1'b0, 32'h3800_0020, 32'h0, 4'hF, 0, 0, 0, lat, rd, to, ob, oh, ra, dn);
        tests++;
        if (!dn || lat != TIMEOUT || !ob) begin
            failed++; $display("FAIL timeout_len: got %0d cycles, required %0d", lat, TIMEOUT);
        end
        tests++;
        if (to !== 1'b1 || rd !== 32'h0 || !ra) begin
            failed++; $display("FAIL timeout_rsp: got to=%b dat=%h ready=%0d, required 1/0/1", to, rd, ra);
        end
        model(1'b0, 32'h3800_0010, 32'h0, 4'hF, 3, e_lat, e_rd, e_to);
        run_txn(1'b0, 32'h3800_0010, 32'h0, 4'hF, 3, 0, 0, lat, rd, to, ob, oh, ra, dn);
        tests++;
        if (!dn || lat != 3 || rd !== e_rd || to !== 1'b0) begin
            failed++; $display("FAIL after_timeout: got lat=%0d dat=%h, required 3/%h", lat, rd, e_rd);
        end
        model(1'b0, 32'h3800_0010, 32'h0, 4'hF, TIMEOUT, e_lat, e_rd, e_to);
        run_txn(1'b0, 32'h3800_0010, 32'h0, 4'hF, TIMEOUT, 0, 0, lat, rd, to, ob, oh, ra, dn);
        tests++;
        if (!dn || lat != TIMEOUT || to !== 1'b0 || rd !== e_rd) begin
            failed++; $display("FAIL ack_last_cycle: got lat=%0d to=%b dat=%h, required %0d/0/%h",
                               lat, to, rd, TIMEOUT, e_rd);
        end
    endtask

    task automatic test_backpressure();
        int lat, e_lat; logic [31:0] rd, e_rd; logic to, e_to; bit ob, oh, ra, dn;
        model(1'b0, 32'h3800_0010, 32'h0, 4'hF, 4, e_lat, e_rd, e_to);
        run_txn(1'b0, 32'h3800_0010, 32'h0, 4'hF, 4, 5, 1, lat, rd, to, ob, oh, ra, dn);
        tests++;
        if (!dn || !oh || rd !== e_rd) begin
            failed++; $display("FAIL backpressure_hold: got stable=%0d dat=%h, required 1/%h", oh, rd, e_rd);
        end
        tests++;
        if (!ra) begin
            failed++; $display("FAIL backpressure_release: got ready_after=%0d, required 1", ra);
        end
        // Stray acks while idle must not produce anything.
        ack_force = 1'b1;
        repeat (3) @(negedge clk);
        ack_force = 1'b0;
        tests++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || wbm_cyc_o !== 1'b0) begin
            failed++; $display("FAIL idle_ack: got rsp_valid=%b cmd_ready=%b, required 0/1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_random();
        int lat, e_lat, delay, r; logic [31:0] rd, e_rd, adr, dat; logic to, e_to, we;
        logic [3:0] sel; bit ob, oh, ra, dn;
        for (int n = 0; n < 20; n++) begin
            we    = 1'($urandom_range(0, 1));
            adr   = 32'h3800_0000 | (32'($urandom_range(0, 15)) << 2);
            dat   = $urandom;
            sel   = 4'($urandom_range(1, 15));
            r     = $urandom_range(0, 9);
            delay = (r == 0) ? 0 : (r == 1) ? $urandom_range(60, 70) : $urandom_range(1, 20);
            model(we, adr, dat, sel, delay, e_lat, e_rd, e_to);
            run_txn(we, adr, dat, sel, delay, $urandom_range(0, 2), 0, lat, rd, to, ob, oh, ra, dn);
            tests++;
            if (!dn || lat != e_lat || rd !== e_rd || to !== e_to || !ob || !oh || !ra) begin
                failed++;
                $display("FAIL random_%0d: got lat=%0d dat=%h to=%b bus=%0d hold=%0d rdy=%0d, required lat=%0d dat=%h to=%b",
                         n, lat, rd, to, ob, oh, ra, e_lat, e_rd, e_to);
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        ack_delay = 0;
        @(negedge clk);
        cmd_we = 1'b0; cmd_adr = 32'h3800_0040; cmd_sel = 4'hF; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || rsp_valid !== 1'b0 ||
            cmd_ready !== 1'b1 || wbm_adr_o !== 32'h0) begin
            failed++; $display("FAIL reset_mid: got cyc=%b stb=%b rsp_valid=%b cmd_ready=%b adr=%h, required 0/0/0/1/0",
                               wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready, wbm_adr_o);
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < TIMEOUT + 16; i++) begin
            @(negedge clk);
            if (rsp_valid || wbm_cyc_o) seen++;
        end
        rsp_ready = 1'b0;
        tests++;
        if (seen != 0) begin
            failed++; $display("FAIL reset_no_rsp: got %0d active cycles, required 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_wait();
        test_timeout();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
